// File: rtl/dbus_axi_bridge_pkg.sv
// Shared types and defaults for the data-bus to AXI4-Lite bridge.
package saratoga;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE,
        ST_DRAIN
    } axi_bridge_state_t;

    localparam int unsigned DEFAULT_AXI_TIMEOUT    = 256;
    localparam int unsigned DEFAULT_AXI_ADDR_WIDTH = 32;
    localparam int unsigned AXI_DATA_WIDTH         = 32;
    localparam int unsigned AXI_STRB_WIDTH         = AXI_DATA_WIDTH / 8;

endpackage

// File: rtl/dbus_axi_bridge.sv
// Core data-bus to AXI4-Lite master bridge, one outstanding transaction.
// Define AXI_BRIDGE_TIMEOUT_EN to add the watchdog and the DRAIN state.
module dbus_axi_bridge
    import saratoga::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_AXI_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      axi_rd_en,
    input  logic                      axi_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_addr,
    input  logic [AXI_DATA_WIDTH-1:0] wr_data,
    input  logic [AXI_STRB_WIDTH-1:0] wr_strobe,
    output logic [AXI_DATA_WIDTH-1:0] axi_rd_data,
    output logic                      axi_busy,
    output logic                      axi_access_fault,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]                m_awprot,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [AXI_DATA_WIDTH-1:0] m_wdata,
    output logic [AXI_STRB_WIDTH-1:0] m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]                m_arprot,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    axi_bridge_state_t         state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AXI_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                      fault_q, fault_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      bready_q, bready_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q, rready_d;
    logic                      is_wr_q, is_wr_d;
    logic                      resp_pend_q, resp_pend_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = awvalid_q & m_awready;
    assign w_hs  = wvalid_q & m_wready;
    assign b_hs  = bready_q & m_bvalid;
    assign ar_hs = arvalid_q & m_arready;
    assign r_hs  = rready_q & m_rvalid;

`ifdef AXI_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_any;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rd_data_q   <= '0;
            fault_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            is_wr_q     <= 1'b0;
            resp_pend_q <= 1'b0;
`ifdef AXI_BRIDGE_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rd_data_q   <= rd_data_d;
            fault_q     <= fault_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            is_wr_q     <= is_wr_d;
            resp_pend_q <= resp_pend_d;
`ifdef AXI_BRIDGE_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rd_data_d   = rd_data_q;
        fault_d     = fault_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        is_wr_d     = is_wr_q;
        resp_pend_d = resp_pend_q;
`ifdef AXI_BRIDGE_TIMEOUT_EN
        cnt_d       = '0;
        pend_any    = 1'b0;
`endif

        // A valid only ever drops on its own handshake.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (ar_hs) arvalid_d = 1'b0;
        if (b_hs || r_hs) resp_pend_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (axi_wr_en) begin
                    addr_d      = axi_addr;
                    wdata_d     = wr_data;
                    wstrb_d     = wr_strobe;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    is_wr_d     = 1'b1;
                    resp_pend_d = 1'b1;
                    state_d     = ST_WR;
                end else if (axi_rd_en) begin
                    addr_d      = axi_addr;
                    arvalid_d   = 1'b1;
                    is_wr_d     = 1'b0;
                    resp_pend_d = 1'b1;
                    state_d     = ST_RD_ADDR;
                end
            end
            ST_WR: begin
                if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    fault_d  = (axi_resp_t'(m_bresp) != OKAY);
                    bready_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs) begin
                    rready_d = 1'b1;
                    state_d  = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    rd_data_d = m_rdata;
                    fault_d   = (axi_resp_t'(m_rresp) != OKAY);
                    rready_d  = 1'b0;
                    state_d   = ST_DONE;
                end
            end
`ifdef AXI_BRIDGE_TIMEOUT_EN
            ST_DONE, ST_DRAIN: begin
                // After a timeout keep accepting the abandoned response.
                pend_any = awvalid_d | wvalid_d | arvalid_d | resp_pend_d;
                bready_d = is_wr_q & resp_pend_d;
                rready_d = ~is_wr_q & resp_pend_d;
                state_d  = pend_any ? ST_DRAIN : ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef AXI_BRIDGE_TIMEOUT_EN
        // Watchdog: counts cycles spent without a state change.
        if ((state_d == state_q) &&
            (state_q inside {ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA})) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d   = ST_DONE;
                fault_d   = 1'b1;
                rd_data_d = '0;
                bready_d  = is_wr_q & resp_pend_d;
                rready_d  = ~is_wr_q & resp_pend_d;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    assign axi_busy         = (axi_rd_en | axi_wr_en) & (state_q != ST_DONE) & ~rst;
    assign axi_rd_data      = rd_data_q;
    assign axi_access_fault = fault_q;
    assign m_awaddr         = addr_q;
    assign m_awprot         = 3'b000;
    assign m_awvalid        = awvalid_q;
    assign m_wdata          = wdata_q;
    assign m_wstrb          = wstrb_q;
    assign m_wvalid         = wvalid_q;
    assign m_bready         = bready_q;
    assign m_araddr         = addr_q;
    assign m_arprot         = 3'b000;
    assign m_arvalid        = arvalid_q;
    assign m_rready         = rready_q;

endmodule

// File: tb/tb_dbus_axi_bridge.sv
// Scoreboard bench for dbus_axi_bridge with a delay-configurable AXI4-Lite slave.
// Build with AXI_BRIDGE_TIMEOUT_EN to also exercise the watchdog and DRAIN.
module tb_dbus_axi_bridge;
    import saratoga::*;

    localparam int unsigned AW = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        axi_rd_en, axi_wr_en;
    logic [AW-1:0] axi_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic [31:0] axi_rd_data;
    logic        axi_busy, axi_access_fault;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    dbus_axi_bridge #(.AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .axi_rd_en(axi_rd_en), .axi_wr_en(axi_wr_en), .axi_addr(axi_addr),
        .wr_data(wr_data), .wr_strobe(wr_strobe),
        .axi_rd_data(axi_rd_data), .axi_busy(axi_busy), .axi_access_fault(axi_access_fault),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave knobs and state
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  cfg_bresp = 2'd0, cfg_rresp = 2'd0;
    bit          r_ovr_en = 1'b0, b_never = 1'b0;
    logic [31:0] r_ovr = '0;
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    bit          aw_got, w_got, b_pend, r_pend;
    bit          mem_cleared = 1'b0;
    logic [31:0] waddr_l, wdata_l, raddr_l;
    logic [3:0]  wstrb_l;
    logic [31:0] mem [0:63];

    assign m_awready = m_awvalid && (aw_cnt >= aw_dly);
    assign m_wready  = m_wvalid && (w_cnt >= w_dly);
    assign m_bvalid  = b_pend && !b_never;
    assign m_bresp   = cfg_bresp;
    assign m_arready = m_arvalid && (ar_cnt >= ar_dly);
    assign m_rvalid  = r_pend && (r_cnt >= r_dly);
    assign m_rdata   = r_ovr_en ? r_ovr : mem[raddr_l[7:2]];
    assign m_rresp   = cfg_rresp;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin : slave
        logic [31:0] a, d;
        logic [3:0]  s;
        bit          ha, hw, aws, ws;
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            if (!mem_cleared) begin
                for (int i = 0; i < 64; i++) mem[i] <= '0;
                mem_cleared <= 1'b1;
            end
        end else begin
            aws = m_awvalid && m_awready;
            ws  = m_wvalid && m_wready;
            aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
            ha = aw_got || aws;
            hw = w_got || ws;
            a  = aws ? m_awaddr : waddr_l;
            d  = ws ? m_wdata : wdata_l;
            s  = ws ? m_wstrb : wstrb_l;
            if (ha && hw) begin
                mem[a[7:2]] <= merge(mem[a[7:2]], d, s);
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1;
            end else begin
                if (aws) begin aw_got <= 1'b1; waddr_l <= m_awaddr; end
                if (ws) begin w_got <= 1'b1; wdata_l <= m_wdata; wstrb_l <= m_wstrb; end
            end
            if (m_bvalid && m_bready) b_pend <= 1'b0;
            if (m_arvalid && m_arready) begin
                r_pend <= 1'b1; raddr_l <= m_araddr; r_cnt <= 0;
            end else if (r_pend && !m_rvalid) begin
                r_cnt <= r_cnt + 1;
            end
            if (m_rvalid && m_rready) r_pend <= 1'b0;
        end
    end

    typedef struct {
        bit          chk_rd;
        logic [31:0] rdata;
        bit          fault;
        int          stall;
    } exp_t;
    exp_t sb[$];

    // Monitor: retires each DONE against the scoreboard and watches channel rules.
    int stall_cnt = 0;
    bit prev_rst = 1'b1;
    bit p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_cnt = 0;
        end else if (axi_rd_en || axi_wr_en) begin
            if (axi_busy) begin
                stall_cnt++;
            end else if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_fault", 32'(axi_access_fault), 32'(e.fault));
                if (e.chk_rd) chk("done_rdata", axi_rd_data, e.rdata);
                if (e.stall >= 0) chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                stall_cnt = 0;
            end
        end
        if (!rst && !prev_rst) begin
            if (p_awv) chk(p_awr ? "awvalid_drop" : "awvalid_hold", 32'(m_awvalid), p_awr ? 32'd0 : 32'd1);
            if (p_wv)  chk(p_wr ? "wvalid_drop" : "wvalid_hold", 32'(m_wvalid), p_wr ? 32'd0 : 32'd1);
            if (p_arv) chk(p_arr ? "arvalid_drop" : "arvalid_hold", 32'(m_arvalid), p_arr ? 32'd0 : 32'd1);
            if (m_bready) chk("bready_after_aw_w", 32'(m_awvalid | m_wvalid), 32'd0);
        end
        prev_rst = rst;
        p_awv = m_awvalid; p_awr = m_awready;
        p_wv  = m_wvalid;  p_wr  = m_wready;
        p_arv = m_arvalid; p_arr = m_arready;
    end

    // Issue one core access, hold it until the DONE cycle, then release.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit chk_rd, input logic [31:0] exp_rd,
                          input bit exp_f, input int exp_stall, input bit chk_start);
        exp_t e;
        bit   done;
        e.chk_rd = chk_rd; e.rdata = exp_rd; e.fault = exp_f; e.stall = exp_stall;
        sb.push_back(e);
        @(posedge clk); #1;
        axi_rd_en = rd; axi_wr_en = wr; axi_addr = addr; wr_data = data; wr_strobe = strb;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (c == 1 && chk_start) begin
                if (wr) begin
                    chk("start_aw_w_together", {30'd0, m_awvalid, m_wvalid}, 32'd3);
                    chk("start_awaddr", m_awaddr, addr);
                    chk("start_wdata", m_wdata, data);
                    chk("start_wstrb", 32'(m_wstrb), 32'(strb));
                end else begin
                    chk("start_arvalid", 32'(m_arvalid), 32'd1);
                    chk("start_araddr", m_araddr, addr);
                end
            end
            if (!axi_busy) done = 1'b1;
        end
        if (!done) chk("req_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        axi_rd_en = 1'b0; axi_wr_en = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(axi_busy), 32'd0);
        chk({tag, "_awvalid"}, 32'(m_awvalid), 32'd0);
        chk({tag, "_wvalid"}, 32'(m_wvalid), 32'd0);
        chk({tag, "_bready"}, 32'(m_bready), 32'd0);
        chk({tag, "_arvalid"}, 32'(m_arvalid), 32'd0);
        chk({tag, "_rready"}, 32'(m_rready), 32'd0);
        chk({tag, "_rd_data"}, axi_rd_data, 32'd0);
        chk({tag, "_fault"}, 32'(axi_access_fault), 32'd0);
    endtask

    initial begin
        bit found;
        axi_rd_en = 1'b0; axi_wr_en = 1'b0; axi_addr = '0; wr_data = '0; wr_strobe = '0;
        rst = 1'b1;
        #7;
        chk_idle_outputs("reset");
        chk("reset_prot", {26'd0, m_awprot, m_arprot}, 32'd0);
        #15 rst = 1'b0;
        repeat (2) @(posedge clk);

        do_req(0, 1, 32'h40, 32'h12345678, 4'hF, 0, 32'h0, 0, 3, 1);
        chk("mem_0x40", mem[16], 32'h12345678);

        ar_dly = 2; r_dly = 3;
        do_req(1, 0, 32'h40, 32'h0, 4'h0, 1, 32'h12345678, 0, 8, 1);
        ar_dly = 0; r_dly = 0;

        aw_dly = 0; w_dly = 3;
        do_req(0, 1, 32'h44, 32'hAABBCCDD, 4'h5, 0, 32'h0, 0, 6, 1);
        w_dly = 0;
        chk("mem_0x44_strobed", mem[17], 32'h00BB00DD);
        do_req(1, 0, 32'h44, 32'h0, 4'h0, 1, 32'h00BB00DD, 0, 3, 1);

        cfg_rresp = 2'd2; r_ovr_en = 1'b1; r_ovr = 32'hDEADBEEF;
        do_req(1, 0, 32'h48, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1, 3, 1);
        cfg_rresp = 2'd0; r_ovr_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_rd_data", axi_rd_data, 32'hDEADBEEF);
        chk("hold_fault", 32'(axi_access_fault), 32'd1);

        cfg_bresp = 2'd3;
        do_req(0, 1, 32'h4C, 32'h11111111, 4'hF, 0, 32'h0, 1, 3, 1);
        cfg_bresp = 2'd0;

        do_req(1, 1, 32'h50, 32'hCAFEF00D, 4'hF, 0, 32'h0, 0, 3, 1);
        chk("mem_0x50_write_wins", mem[20], 32'hCAFEF00D);

        r_dly = 20;
        @(posedge clk); #1;
        axi_rd_en = 1'b1; axi_addr = 32'h40;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (m_rready) found = 1'b1;
        end
        chk("reach_rd_data", 32'(found), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("midreset");
        axi_rd_en = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        r_dly = 0;
        do_req(1, 0, 32'h40, 32'h0, 4'h0, 1, 32'h12345678, 0, 3, 1);

`ifdef AXI_BRIDGE_TIMEOUT_EN
        b_never = 1'b1;
        do_req(0, 1, 32'h58, 32'h00000001, 4'hF, 1, 32'h0, 1, 10, 1);
        fork
            do_req(1, 0, 32'h40, 32'h0, 4'h0, 1, 32'h12345678, 0, -1, 0);
            begin
                repeat (4) @(negedge clk);
                chk("busy_in_drain", 32'(axi_busy), 32'd1);
                chk("bready_in_drain", 32'(m_bready), 32'd1);
                b_never = 1'b0;
            end
        join
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
